// File: rtl/stream_demux_n_pkg.sv
// Shared constants for the stream demultiplexer: default geometry and counter width.
// Counter logic elsewhere is only built when DEMUX_CNT_EN is defined.
package stream_demux_n_pkg;

  localparam int DEMUX_CNT_W    = 16;
  localparam int DEMUX_N_CH_DEF = 4;
  localparam int DEMUX_DW_DEF   = 8;
  localparam int DEMUX_SW_DEF   = 2;

  // Bit offset of a channel's counter inside the flattened counter bus.
  function automatic int cntLsb(input int ch);
    return ch * DEMUX_CNT_W;
  endfunction

endpackage

// File: rtl/stream_demux_n_if.sv
// Producer-side and consumer-side handshake bundle of the 1-to-N stream demultiplexer.
interface stream_demux_n_if #(
  parameter int N_CH = 4,
  parameter int DW   = 8,
  parameter int SW   = 2
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic [SW-1:0]     in_sel;
  logic [N_CH-1:0]   out_valid;
  logic [N_CH-1:0]   out_ready;
  logic [N_CH*DW-1:0] out_data;

  // master: the environment (producer plus consumers); slave: the demux itself.
  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/stream_demux_n_out_slot.sv
// Module demux_out_slot: one-entry output register for a single demux channel.
// With DEMUX_CNT_EN defined it also counts output handshakes (wrapping 16-bit counter).
module demux_out_slot
  import stream_demux_n_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          accept_i,
  input  logic          ready_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o
`ifdef DEMUX_CNT_EN
  ,
  output logic [DEMUX_CNT_W-1:0] cnt_o
`endif
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic          drain;

  assign drain = valid_q && ready_i;

  // A new beat wins over a drain so the slot sustains one beat per cycle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (accept_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

`ifdef DEMUX_CNT_EN
  logic [DEMUX_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (drain) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/stream_demux_n.sv
// Parametrised 1-to-N valid/ready stream demux with one registered slot per channel and
// sticky out-of-range select flag. Optional per-channel handshake counters via DEMUX_CNT_EN.
module stream_demux_n
  import stream_demux_n_pkg::*;
#(
  parameter int N_CH = DEMUX_N_CH_DEF,
  parameter int DW   = DEMUX_DW_DEF,
  parameter int SW   = DEMUX_SW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  stream_demux_n_if.slave bus,
  output logic           err_sel
`ifdef DEMUX_CNT_EN
  ,
  output logic [N_CH*DEMUX_CNT_W-1:0] cnt_flat
`endif
);

  logic [N_CH-1:0] selHit;
  logic [N_CH-1:0] slotFree;
  logic [N_CH-1:0] slotValid;
  logic [N_CH-1:0] accept;
  logic            inRange;
  logic            errSel_q, errSel_d;

  // One-hot select decode; codes at or above N_CH hit nothing and are dropped.
  always_comb begin
    selHit = '0;
    for (int i = 0; i < N_CH; i++) begin
      selHit[i] = (bus.in_sel == SW'(i));
    end
  end

  assign inRange      = |selHit;
  assign slotFree     = ~slotValid | bus.out_ready;
  assign bus.in_ready = !inRange || (|(selHit & slotFree));
  assign accept       = {N_CH{bus.in_valid}} & selHit & slotFree;

  always_comb begin
    errSel_d = errSel_q;
    if (bus.in_valid && !inRange) errSel_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) errSel_q <= 1'b0;
    else        errSel_q <= errSel_d;
  end

  assign err_sel = errSel_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_slot
    demux_out_slot #(
      .DW(DW)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .accept_i (accept[i]),
      .ready_i  (bus.out_ready[i]),
      .data_i   (bus.in_data),
      .valid_o  (slotValid[i]),
      .data_o   (bus.out_data[i*DW +: DW])
`ifdef DEMUX_CNT_EN
      ,
      .cnt_o    (cnt_flat[cntLsb(i) +: DEMUX_CNT_W])
`endif
    );
  end

  assign bus.out_valid = slotValid;

endmodule

// File: tb/tb_stream_demux_n.sv
// Directed self-checking bench: a 4-channel demux for routing/back-pressure/reset and
// a 3-channel demux for out-of-range selects; counter wrap checked when DEMUX_CNT_EN is defined.
module tb_stream_demux_n;

  logic clk;
  logic rst_n;
  logic errSelA, errSelB;
  int   assertCount = 0;
  int   failCount   = 0;

  stream_demux_n_if #(.N_CH(4), .DW(8), .SW(2)) busA ();
  stream_demux_n_if #(.N_CH(3), .DW(8), .SW(2)) busB ();

`ifdef DEMUX_CNT_EN
  logic [63:0] cntFlatA;
  logic [47:0] cntFlatB;
`endif

  stream_demux_n #(.N_CH(4), .DW(8), .SW(2)) dutA (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (busA.slave),
    .err_sel (errSelA)
`ifdef DEMUX_CNT_EN
    ,
    .cnt_flat(cntFlatA)
`endif
  );

  stream_demux_n #(.N_CH(3), .DW(8), .SW(2)) dutB (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (busB.slave),
    .err_sel (errSelB)
`ifdef DEMUX_CNT_EN
    ,
    .cnt_flat(cntFlatB)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic valid, input logic [1:0] sel, input logic [7:0] data);
    busA.in_valid = valid;
    busA.in_sel   = sel;
    busA.in_data  = data;
  endtask

  initial begin
    rst_n          = 1'b0;
    busA.out_ready = 4'b1111;
    busB.out_ready = 3'b111;
    busB.in_valid  = 1'b0;
    busB.in_sel    = 2'd0;
    busB.in_data   = 8'h00;
    applyStimulus(1'b1, 2'd0, 8'h11);
    @(negedge clk);

    // Reset held with a valid beat presented
    tick();
    tick();
    checkOutput("rst_valid", 64'(busA.out_valid), 64'h0);
    checkOutput("rst_data", 64'(busA.out_data), 64'h0);
    checkOutput("rst_err", 64'(errSelA), 64'h0);
`ifdef DEMUX_CNT_EN
    checkOutput("rst_cnt", cntFlatA, 64'h0);
`endif
    rst_n = 1'b1;
    applyStimulus(1'b0, 2'd0, 8'h00);
    tick();
    checkOutput("idle_valid", 64'(busA.out_valid), 64'h0);

    // Routing with every consumer ready
    applyStimulus(1'b1, 2'd0, 8'hA5);
    #1 checkOutput("route_rdy0", 64'(busA.in_ready), 64'h1);
    tick();
    checkOutput("route_v0", 64'(busA.out_valid), 64'h1);
    checkOutput("route_d0", 64'(busA.out_data[7:0]), 64'hA5);
    applyStimulus(1'b1, 2'd1, 8'h3C);
    tick();
    checkOutput("route_v1", 64'(busA.out_valid), 64'h2);
    checkOutput("route_d1", 64'(busA.out_data[15:8]), 64'h3C);
    applyStimulus(1'b1, 2'd2, 8'h00);
    tick();
    checkOutput("route_v2_zero", 64'(busA.out_valid), 64'h4);
    checkOutput("route_d2", 64'(busA.out_data[23:16]), 64'h00);
    applyStimulus(1'b1, 2'd3, 8'hFF);
    tick();
    checkOutput("route_v3", 64'(busA.out_valid), 64'h8);
    applyStimulus(1'b0, 2'd0, 8'h00);
    tick();
    checkOutput("route_drained", 64'(busA.out_valid), 64'h0);
    checkOutput("route_data_held", 64'(busA.out_data), 64'hFF003CA5);

    // Back-pressure on channel 1
    busA.out_ready = 4'b1101;
    applyStimulus(1'b1, 2'd1, 8'hA5);
    #1 checkOutput("bp_rdy_first", 64'(busA.in_ready), 64'h1);
    tick();
    checkOutput("bp_v_first", 64'(busA.out_valid), 64'h2);
    applyStimulus(1'b1, 2'd1, 8'h77);
    #1 checkOutput("bp_rdy_stalled", 64'(busA.in_ready), 64'h0);
    tick();
    checkOutput("bp_v_stalled", 64'(busA.out_valid), 64'h2);
    checkOutput("bp_d_held", 64'(busA.out_data[15:8]), 64'hA5);
    applyStimulus(1'b1, 2'd2, 8'h5A);
    #1 checkOutput("bp_rdy_other", 64'(busA.in_ready), 64'h1);
    tick();
    checkOutput("bp_v_other", 64'(busA.out_valid), 64'h6);
    checkOutput("bp_d_other", 64'(busA.out_data[23:16]), 64'h5A);
    checkOutput("bp_d1_still", 64'(busA.out_data[15:8]), 64'hA5);
    busA.out_ready = 4'b1111;
    applyStimulus(1'b1, 2'd1, 8'h77);
    #1 checkOutput("bp_rdy_release", 64'(busA.in_ready), 64'h1);
    tick();
    checkOutput("bp_v_release", 64'(busA.out_valid), 64'h2);
    checkOutput("bp_d_release", 64'(busA.out_data[15:8]), 64'h77);
    applyStimulus(1'b0, 2'd0, 8'h00);
    tick();
    checkOutput("bp_v_empty", 64'(busA.out_valid), 64'h0);
`ifdef DEMUX_CNT_EN
    // ch0:1 ch1:3 ch2:2 ch3:1 handshakes so far
    checkOutput("cnt_after_bp", cntFlatA, 64'h0001_0002_0003_0001);
`endif

    // Out-of-range select on the 3-channel demux
    busB.in_valid = 1'b1;
    busB.in_sel   = 2'd3;
    busB.in_data  = 8'hEE;
    #1 checkOutput("oor_rdy", 64'(busB.in_ready), 64'h1);
    tick();
    checkOutput("oor_valid", 64'(busB.out_valid), 64'h0);
    checkOutput("oor_err", 64'(errSelB), 64'h1);
    busB.in_valid = 1'b0;
    tick();
    checkOutput("oor_err_sticky", 64'(errSelB), 64'h1);
    busB.in_valid = 1'b1;
    busB.in_sel   = 2'd0;
    busB.in_data  = 8'h42;
    tick();
    busB.in_valid = 1'b0;
    checkOutput("oor_then_valid", 64'(busB.out_valid), 64'h1);
    checkOutput("oor_then_data", 64'(busB.out_data[7:0]), 64'h42);
    checkOutput("oor_err_held", 64'(errSelB), 64'h1);

    // Mid-stream reset with every slot full
    busA.out_ready = 4'b0000;
    busB.out_ready = 3'b000;
    applyStimulus(1'b1, 2'd0, 8'h11); tick();
    applyStimulus(1'b1, 2'd1, 8'h22); tick();
    applyStimulus(1'b1, 2'd2, 8'h33); tick();
    applyStimulus(1'b1, 2'd3, 8'h44); tick();
    applyStimulus(1'b0, 2'd0, 8'h00);
    checkOutput("full_valid", 64'(busA.out_valid), 64'hF);
    checkOutput("full_data", 64'(busA.out_data), 64'h44332211);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("mid_rst_valid", 64'(busA.out_valid), 64'h0);
    checkOutput("mid_rst_data", 64'(busA.out_data), 64'h0);
    checkOutput("mid_rst_validB", 64'(busB.out_valid), 64'h0);
    checkOutput("mid_rst_errB", 64'(errSelB), 64'h0);
    busA.out_ready = 4'b1111;
    busB.out_ready = 3'b111;

`ifdef DEMUX_CNT_EN
    // Counter wrap on channel 0
    checkOutput("cnt_cleared", cntFlatA, 64'h0);
    applyStimulus(1'b1, 2'd0, 8'h5C);
    for (int i = 0; i < 65535; i++) tick();
    applyStimulus(1'b0, 2'd0, 8'h00);
    tick();
    checkOutput("cnt_preload", cntFlatA, 64'h0000_0000_0000_FFFF);
    applyStimulus(1'b1, 2'd0, 8'hC5);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00);
    tick();
    checkOutput("cnt_wrap", cntFlatA, 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
